// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
package run_ctrl_pkg;

   // Controller states; encoding kept stable for anything that decodes state.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_LOAD = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Default number of cycles the core is held in reset before the PC load.
   localparam int unsigned RST_CYC_DEF = 2;

   // Default watchdog limit, in RUN cycles.
   localparam int unsigned MAX_CYC_DEF = 1000;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_q;

   // Clear has priority over counting; counting stops at the maximum value.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: resets the core, loads its PC, runs it and reports
// completion on halt or on watchdog expiry. All outputs are registered.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int D       = 12,
   parameter int CW      = 16,
   parameter int RST_CYC = RST_CYC_DEF,
   parameter int MAX_CYC = MAX_CYC_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [D-1:0]  start_addr,
   input  logic          core_halt,
   output logic          core_rst,
   output logic          core_en,
   output logic          pc_load,
   output logic [D-1:0]  pc_init,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycle_cnt
);

   // Last INIT count before moving on, and the cycle count that trips the watchdog.
   localparam logic [3:0]    INIT_LAST = 4'(RST_CYC - 1);
   localparam logic [CW-1:0] WDOG_LAST = CW'(MAX_CYC - 1);

   state_e       state_q,    state_d;
   logic [3:0]   init_cnt_q, init_cnt_d;
   logic [D-1:0] pc_init_q,  pc_init_d;
   logic         timeout_q,  timeout_d;
   logic         core_rst_q, core_rst_d;
   logic         core_en_q,  core_en_d;
   logic         pc_load_q,  pc_load_d;
   logic         busy_q,     busy_d;
   logic         done_q,     done_d;
   logic         cnt_clr;
   logic         cnt_en;

   // RUN-cycle counter: cleared when a request is accepted, advances on every RUN edge.
   sat_counter #(
      .W (CW)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .cnt_o (cycle_cnt)
   );

   // Next-state logic: request acceptance, INIT timing and RUN exit conditions.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case infers a latch.
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      pc_init_d  = pc_init_q;
      timeout_d  = timeout_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (req) begin
               state_d    = ST_INIT;
               init_cnt_d = '0;
               pc_init_d  = start_addr;
               timeout_d  = 1'b0;
               cnt_clr    = 1'b1;
            end
         end
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d = ST_LOAD;
            end else begin
               init_cnt_d = init_cnt_q + 4'd1;
            end
         end
         ST_LOAD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_en = 1'b1;
            // Halt is tested first so it wins over a simultaneous watchdog expiry.
            if (core_halt) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
            end else if (cycle_cnt == WDOG_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      core_rst_d = (state_d == ST_IDLE) || (state_d == ST_INIT);
      core_en_d  = (state_d == ST_RUN);
      pc_load_d  = (state_d == ST_LOAD);
      busy_d     = (state_d == ST_INIT) || (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d     = (state_d == ST_DONE);
   end

   // State and output registers; reset aborts any run without producing done.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         init_cnt_q <= '0;
         pc_init_q  <= '0;
         timeout_q  <= 1'b0;
         core_rst_q <= 1'b1;
         core_en_q  <= 1'b0;
         pc_load_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         pc_init_q  <= pc_init_d;
         timeout_q  <= timeout_d;
         core_rst_q <= core_rst_d;
         core_en_q  <= core_en_d;
         pc_load_q  <= pc_load_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign core_rst = core_rst_q;
   assign core_en  = core_en_q;
   assign pc_load  = pc_load_q;
   assign pc_init  = pc_init_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: each run pushes its expected outcome, and a
// negedge monitor measures the run and compares when done rises.
module tb_run_ctrl;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic        req        = 1'b0;
   logic [11:0] start_addr = '0;
   logic        core_halt  = 1'b0;
   logic        core_rst;
   logic        core_en;
   logic        pc_load;
   logic [11:0] pc_init;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] cycle_cnt;

   typedef struct {
      logic [11:0] pc;
      logic        to;
      logic [15:0] cnt;
      int          en_n;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   run_ctrl #(
      .D       (12),
      .CW      (16),
      .RST_CYC (2),
      .MAX_CYC (20)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .start_addr (start_addr),
      .core_halt  (core_halt),
      .core_rst   (core_rst),
      .core_en    (core_en),
      .pc_load    (pc_load),
      .pc_init    (pc_init),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cycle_cnt  (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: measures INIT length, PC load and enabled cycles of each run.
   int          init_n, load_n, en_n;
   logic [11:0] load_pc;
   logic        prev_busy, prev_done;

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         init_n    = 0;
         load_n    = 0;
         en_n      = 0;
         load_pc   = '0;
         prev_busy = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            init_n = 0;
            load_n = 0;
            en_n   = 0;
         end
         if (busy && core_rst) init_n++;
         if (pc_load) begin
            load_n++;
            load_pc = pc_init;
         end
         if (core_en) en_n++;
         if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("init_cycles", init_n, 2);
               check("pc_load_cycles", load_n, 1);
               check("pc_init_at_load", {20'd0, load_pc}, {20'd0, e.pc});
               check("run_cycles", en_n, e.en_n);
               check("timeout", {31'd0, timeout}, {31'd0, e.to});
               check("cycle_cnt", {16'd0, cycle_cnt}, {16'd0, e.cnt});
               check("busy_at_done", {31'd0, busy}, 32'd0);
            end
         end
         prev_busy = busy;
         prev_done = done;
      end
   end

   // One run: accept req, optionally hold req for hold_run RUN cycles,
   // assert halt on RUN cycle halt_at (0 = never), wait for done.
   task automatic do_run(input logic [11:0] addr, input int halt_at, input logic exp_to,
                         input int exp_cnt, input int hold_run);
      exp_t e;
      int   rc;
      int   w;
      e.pc   = addr;
      e.to   = exp_to;
      e.cnt  = 16'(exp_cnt);
      e.en_n = exp_cnt;
      sb_q.push_back(e);

      req        = 1'b1;
      start_addr = addr;
      tick();
      check("accept_busy", {31'd0, busy}, 32'd1);
      check("accept_done_clr", {31'd0, done}, 32'd0);
      check("accept_cnt_clr", {16'd0, cycle_cnt}, 32'd0);
      check("accept_pc_init", {20'd0, pc_init}, {20'd0, addr});
      if (hold_run == 0) req = 1'b0;

      w = 0;
      while (!core_en && w < 10) begin
         tick();
         w++;
      end
      if (!core_en) begin
         check("core_en_start", 32'd0, 32'd1);
         req = 1'b0;
         return;
      end

      rc = 1;
      while (!done && rc <= 100) begin
         if (rc > hold_run) req = 1'b0;
         if (rc == halt_at) core_halt = 1'b1;
         tick();
         core_halt = 1'b0;
         if (!done) rc++;
      end
      req = 1'b0;
      check("done_seen", {31'd0, done}, 32'd1);
      check("core_en_after", {31'd0, core_en}, 32'd0);
      tick();
      tick();
      check("done_held", {31'd0, done}, 32'd1);
      check("cnt_frozen", {16'd0, cycle_cnt}, {16'd0, 16'(exp_cnt)});
   endtask

   initial begin
      // Reset with req asserted: nothing may start.
      reset      = 1'b0;
      req        = 1'b1;
      start_addr = 12'hFFF;
      tick();
      tick();
      check("rst_core_rst", {31'd0, core_rst}, 32'd1);
      check("rst_core_en", {31'd0, core_en}, 32'd0);
      check("rst_pc_load", {31'd0, pc_load}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
      check("rst_pc_init", {20'd0, pc_init}, 32'd0);
      req   = 1'b0;
      reset = 1'b1;
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Normal run, halt on RUN cycle 5.
      do_run(12'h040, 5, 1'b0, 5, 0);
      // Watchdog expiry after 20 RUN cycles.
      do_run(12'h0AB, 0, 1'b1, 20, 0);
      // Halt on the same edge as the watchdog limit: halt wins.
      do_run(12'h0CD, 20, 1'b0, 20, 0);
      // req held through INIT/LOAD and into RUN is ignored.
      do_run(12'h0EE, 4, 1'b0, 4, 2);
      // Restart from DONE with a new start address.
      do_run(12'h100, 3, 1'b0, 3, 0);

      // Reset on RUN cycle 3 aborts without done.
      req        = 1'b1;
      start_addr = 12'h055;
      tick();
      req = 1'b0;
      for (int i = 0; i < 10 && !core_en; i++) tick();
      tick();
      tick();
      check("pre_abort_cnt", {16'd0, cycle_cnt}, 32'd2);
      reset = 1'b0;
      tick();
      check("abort_core_rst", {31'd0, core_rst}, 32'd1);
      check("abort_core_en", {31'd0, core_en}, 32'd0);
      check("abort_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      tick();
      tick();
      tick();
      check("abort_stays_idle", {31'd0, busy}, 32'd0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
